// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline stall/flush controller.
// Stall bus bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; a set bit stops that stage.
package pipe_ctrl_pkg;

    localparam int STALL_BUS = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_BUS-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_BUS-1:0] STALL_EX   = 6'b001111;

    // Index of the decode-stage bit in the stall bus.
    localparam int STALL_ID_BIT = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ID_STALL = 2'd1,
        EX_STALL = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_inst_hold_buf.sv
// Holds the fetched instruction while decode is stalled, so the word survives
// the SRAM read data moving on; stays valid for exactly one post-stall cycle.
module inst_hold_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        capture,
    input  logic        release_hold,
    input  logic        clear,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        hold
);

    // NOTE: the buffer is a single register, not a memory array, so it is
    // cheap to reset and a reset mid-stall must discard its contents anyway.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold <= 1'b0;
            dout <= '0;
        end else if (clear) begin
            hold <= 1'b0;
        end else if (hold) begin
            if (release_hold) hold <= 1'b0;
        end else if (capture) begin
            // NOTE: non-blocking assignments keep every register sampling
            // the pre-edge values, independent of statement order.
            hold <= 1'b1;
            dout <= din;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: combinational stall bus, redirect PC and an
// instruction hold buffer for the decode stage. PIPE_CTRL_PERF_EN adds stall counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 stallreq_id,
    input  logic                 stallreq_ex,
    input  logic                 flush_req,
    input  logic [31:0]          flush_pc,
    input  logic [31:0]          inst_sram_rdata,
    output logic [STALL_BUS-1:0] stall,
    output logic                 flush,
    output logic [31:0]          new_pc,
    output logic [31:0]          id_inst,
    output logic [1:0]           state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_id_stall,
    output logic [31:0]          perf_ex_stall
`endif
);

    state_e               state_q, state_d;
    logic [STALL_BUS-1:0] stall_enc;
    logic [31:0]          buf_data;
    logic                 hold;

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        stall_enc = STALL_NONE;
        state_d   = RUN;
        if (!flush_req) begin
            if (stallreq_ex) begin
                stall_enc = STALL_EX;
                state_d   = EX_STALL;
            end else if (stallreq_id) begin
                stall_enc = STALL_ID;
                state_d   = ID_STALL;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= RUN;
        else         state_q <= state_d;
    end

    // Outputs are forced quiet while reset is held, even though they are combinational.
    assign stall   = resetn ? stall_enc : STALL_NONE;
    assign flush   = resetn & flush_req;
    assign new_pc  = flush ? flush_pc : 32'b0;
    assign state_o = state_q;

    inst_hold_buf u_hold_buf (
        .clk          (clk),
        .resetn       (resetn),
        .capture      (stall[STALL_ID_BIT] == STOP),
        .release_hold (stall[STALL_ID_BIT] == NO_STOP),
        .clear        (flush),
        .din          (inst_sram_rdata),
        .dout         (buf_data),
        .hold         (hold)
    );

    assign id_inst = hold ? buf_data : inst_sram_rdata;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_id_stall <= '0;
            perf_ex_stall <= '0;
        end else begin
            if (stall == STALL_ID) perf_id_stall <= perf_id_stall + 32'd1;
            if (stall == STALL_EX) perf_ex_stall <= perf_ex_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port stallreq_id, input, 1 bit: load-use hazard request from the decode stage.
REQ-004 The block SHALL have port stallreq_ex, input, 1 bit: multi-cycle execute busy (mul/div).
REQ-005 The block SHALL have port flush_req, input, 1 bit: exception/redirect from the memory stage.
REQ-006 The block SHALL have port flush_pc, input, 32 bits: redirect target, valid with flush_req.
REQ-007 The block SHALL have port inst_sram_rdata, input, 32 bits: instruction SRAM read data.
REQ-008 The block SHALL have port stall, output, `StallBus` (6) bits: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-009 The block SHALL have port flush, output, 1 bit: pipeline flush pulse.
REQ-010 The block SHALL have port new_pc, output, 32 bits: PC to load when flush=1.
REQ-011 The block SHALL have port id_inst, output, 32 bits: instruction presented to decode.
REQ-012 The block SHALL have port state_o, output, 2 bits: current FSM state, for debug.

Function
REQ-013 The block SHALL have FSM states RUN=0, ID_STALL=1, EX_STALL=2, with priority flush_req > stallreq_ex > stallreq_id.
REQ-014 stall SHALL be combinational from the requests: flush_req -> 6'b000000, stallreq_ex -> 6'b001111, stallreq_id -> 6'b000111, none -> 6'b000000.
REQ-015 flush SHALL equal flush_req in the same cycle; new_pc SHALL equal flush_pc when flush=1 and 32'b0 otherwise.
REQ-016 The next state SHALL be EX_STALL if stallreq_ex, else ID_STALL if stallreq_id, else RUN; flush_req SHALL force RUN.
REQ-017 The block SHALL keep a hold flag and a 32-bit buffer: on a cycle with stall[2]=1 and hold=0 it captures inst_sram_rdata and sets hold=1.
REQ-018 While hold=1 the buffer SHALL NOT be rewritten, and id_inst SHALL equal the buffer; otherwise id_inst SHALL equal inst_sram_rdata.
REQ-019 The block SHALL clear hold at the edge after the first cycle with stall[2]=0, so exactly one post-stall cycle still uses the buffer, or immediately on flush_req.
REQ-020 If stallreq_id and stallreq_ex are both high, the block SHALL use the EX encoding; when stallreq_ex drops while stallreq_id stays high, it SHALL go EX_STALL -> ID_STALL with hold preserved.
REQ-021 Latency SHALL be zero cycles from request to stall, and one cycle from request to state_o/hold update.

Reset
REQ-022 While resetn=0 the block SHALL hold state=RUN, hold=0, buffer=0, and outputs stall=0, flush=0, new_pc=0, id_inst=inst_sram_rdata.
REQ-023 Reset asserted mid-stall SHALL discard the buffer immediately; the first cycle after release SHALL behave as RUN.

Configuration
REQ-024 With PIPE_CTRL_PERF_EN defined, the block SHALL add outputs perf_id_stall[31:0] and perf_ex_stall[31:0], each counting cycles with the ID or EX encoding, wrapping at 2^32 and reset to 0.
REQ-025 With PIPE_CTRL_PERF_EN undefined, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-026 StallBus, Stop/NoStop and the state encodings SHALL live in lib/defines.vh; the stall encodings SHALL be named constants there.
REQ-027 The hold flag and buffer SHALL be one sub-module, inst_hold_buf (ports clk, resetn, capture, release, clear, din, dout, hold).

Verification
REQ-028 Reset: resetn=0 with random inputs -> stall=0, flush=0, new_pc=0, state_o=0.
REQ-029 Load-use: stallreq_id=1 for 1 cycle with rdata=32'h8C220004, then rdata changes to 32'hDEADBEEF -> stall=6'b000111 for 1 cycle, and id_inst=32'h8C220004 for that cycle and the next.
REQ-030 Div busy: stallreq_ex=1 for 32 cycles -> stall=6'b001111 for 32 cycles, buffer constant; with PERF_EN, perf_ex_stall=32.
REQ-031 Overlap: stallreq_ex and stallreq_id high together, then ex drops -> 6'b001111, then 6'b000111, state 2 -> 1, hold stays 1.
REQ-032 Flush during stall: flush_req=1 with flush_pc=32'hBFC00380 while stallreq_ex=1 -> stall=0, flush=1, new_pc=32'hBFC00380, hold=0 and state RUN next cycle.
REQ-033 Async reset: resetn pulsed low mid-ID_STALL, between clock edges -> state_o=0 and hold=0 without waiting for a clock edge.
